wb_write_port_ctrl: RTL and testbench

- Writer-side controller for the decode-stage register file's single write port (wEn / write_sel / write_data, captured by the register file on the falling clock edge).
- Merges completed results from two producers into a small in-order queue and drains one entry per cycle onto the write port:
  - Port A: ALU/load writeback.
  - Port B: multi-cycle mul/div unit.
- Exposes a two-port forwarding lookup so decode can see results still queued or in flight.

---
 rtl/wb_pkg.sv | 14 +
 rtl/wb_fwd_match.sv | 29 ++
 rtl/wb_write_port_ctrl.sv | 146 ++++++++++++++
 tb/tb_wb_write_port_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared widths, entry type and constants for the writeback write-port controller.
package wb_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  localparam logic [AW-1:0] ZERO_REG = {AW{1'b0}};

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match search over an age-ordered set of pending writeback entries.
module wb_fwd_match
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wb_entry_t [DEPTH-1:0] i_entries,
  input  logic [DEPTH-1:0]      i_valid,
  input  logic [AW-1:0]         i_sel,
  output logic                  o_hit,
  output logic [XLEN-1:0]       o_data
);

  // Index 0 is the oldest entry, so a later match overrides an earlier one.
  always_comb begin
    o_hit  = 1'b0;
    o_data = {XLEN{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      if (i_valid[k] && (i_sel != ZERO_REG) && (i_entries[k].rd == i_sel)) begin
        o_hit  = 1'b1;
        o_data = i_entries[k].data;
      end else begin
        o_hit  = o_hit;
        o_data = o_data;
      end
    end
  end

endmodule

// File: rtl/wb_write_port_ctrl.sv
// Merges ALU/load (A) and mul/div (B) results into an in-order queue that drains
// one entry per cycle onto the register-file write port, with forwarding lookup.
module wb_write_port_ctrl
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [AW-1:0]           a_rd,
  input  logic [XLEN-1:0]         a_data,
  input  logic                    b_valid,
  output logic                    b_ready,
  input  logic [AW-1:0]           b_rd,
  input  logic [XLEN-1:0]         b_data,
  output logic                    rf_wEn,
  output logic [AW-1:0]           rf_write_sel,
  output logic [XLEN-1:0]         rf_write_data,
  input  logic [AW-1:0]           fwd_sel1,
  input  logic [AW-1:0]           fwd_sel2,
  output logic                    fwd_hit1,
  output logic                    fwd_hit2,
  output logic [XLEN-1:0]         fwd_data1,
  output logic [XLEN-1:0]         fwd_data2,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  wb_entry_t       r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            r_wen;
  logic [AW-1:0]   r_sel;
  logic [XLEN-1:0] r_wdata;

  logic [CW-1:0]   w_free;
  logic            w_a_ready;
  logic            w_b_ready;
  logic            w_a_enq;
  logic            w_b_enq;
  logic            w_pop;
  logic [PW-1:0]   w_b_idx;

  wb_entry_t [DEPTH-1:0] w_ord;
  logic [DEPTH-1:0]      w_ord_valid;
  logic                  w_q_hit1;
  logic                  w_q_hit2;
  logic [XLEN-1:0]       w_q_data1;
  logic [XLEN-1:0]       w_q_data2;

  // Readiness looks only at registered occupancy; A takes the last free slot.
  assign w_free    = DEPTH_C - r_count;
  assign w_a_ready = !reset && (w_free >= CW'(1));
  assign w_b_ready = !reset && ((w_free >= CW'(2)) || ((w_free >= CW'(1)) && !a_valid));

  // Results for x0 handshake normally but never occupy a slot.
  assign w_a_enq = a_valid && w_a_ready && (a_rd != ZERO_REG);
  assign w_b_enq = b_valid && w_b_ready && (b_rd != ZERO_REG);
  assign w_pop   = (r_count != {CW{1'b0}});
  assign w_b_idx = r_wptr + PW'(w_a_enq);

  // Queue storage: A is written ahead of B so it stays the older entry.
  always_ff @(posedge clock) begin
    if (w_a_enq) r_mem[r_wptr]  <= '{rd: a_rd, data: a_data};
    if (w_b_enq) r_mem[w_b_idx] <= '{rd: b_rd, data: b_data};
  end

  // Pointers, occupancy and the registered write-port stage.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr  <= {PW{1'b0}};
      r_rptr  <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
      r_wen   <= 1'b0;
      r_sel   <= {AW{1'b0}};
      r_wdata <= {XLEN{1'b0}};
    end else begin
      r_wptr  <= r_wptr + PW'(w_a_enq) + PW'(w_b_enq);
      r_count <= r_count + CW'(w_a_enq) + CW'(w_b_enq) - CW'(w_pop);
      r_wen   <= w_pop;
      if (w_pop) begin
        r_rptr  <= r_rptr + PW'(1);
        r_sel   <= r_mem[r_rptr].rd;
        r_wdata <= r_mem[r_rptr].data;
      end
    end
  end

  // Present the queue oldest-first with a validity mask for the search.
  for (genvar k = 0; k < DEPTH; k++) begin : g_ord
    assign w_ord[k]       = r_mem[r_rptr + PW'(k)];
    assign w_ord_valid[k] = (CW'(k) < r_count);
  end

  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
    .i_entries (w_ord),
    .i_valid   (w_ord_valid),
    .i_sel     (fwd_sel1),
    .o_hit     (w_q_hit1),
    .o_data    (w_q_data1)
  );

  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
    .i_entries (w_ord),
    .i_valid   (w_ord_valid),
    .i_sel     (fwd_sel2),
    .o_hit     (w_q_hit2),
    .o_data    (w_q_data2)
  );

  // Output stage is older than anything queued, so it only answers on a queue miss.
  always_comb begin
    if (!w_q_hit1 && r_wen && (fwd_sel1 != ZERO_REG) && (r_sel == fwd_sel1)) begin
      fwd_hit1  = 1'b1;
      fwd_data1 = r_wdata;
    end else begin
      fwd_hit1  = w_q_hit1;
      fwd_data1 = w_q_data1;
    end
    if (!w_q_hit2 && r_wen && (fwd_sel2 != ZERO_REG) && (r_sel == fwd_sel2)) begin
      fwd_hit2  = 1'b1;
      fwd_data2 = r_wdata;
    end else begin
      fwd_hit2  = w_q_hit2;
      fwd_data2 = w_q_data2;
    end
  end

  assign a_ready       = w_a_ready;
  assign b_ready       = w_b_ready;
  assign rf_wEn        = r_wen;
  assign rf_write_sel  = r_sel;
  assign rf_write_data = r_wdata;
  assign count         = r_count;
  assign full          = (r_count == DEPTH_C);
  assign empty         = (r_count == {CW{1'b0}});

endmodule

// File: tb/tb_wb_write_port_ctrl.sv
// Self-checking bench for wb_write_port_ctrl against a queue-based reference model.
module tb_wb_write_port_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [4:0]  a_rd, b_rd, fwd_sel1, fwd_sel2, rf_write_sel;
  logic [31:0] a_data, b_data, rf_write_data, fwd_data1, fwd_data2;
  logic        rf_wEn, fwd_hit1, fwd_hit2, full, empty;
  logic [2:0]  count;

  always #5 clock = ~clock;

  wb_write_port_ctrl dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .rf_wEn(rf_wEn), .rf_write_sel(rf_write_sel), .rf_write_data(rf_write_data),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .count(count), .full(full), .empty(empty)
  );

  typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;

  // Reference model: pending writes in acceptance order plus the write-port stage.
  ent_t        mq[$];
  bit          m_wen;
  logic [4:0]  m_sel;
  logic [31:0] m_data;

  int checks = 0;
  int failures = 0;

  bit          exp_ar, exp_br, exp_h1, exp_h2;
  logic [31:0] exp_d1, exp_d2;
  logic        obs_ar, obs_br, obs_h1, obs_h2;
  logic [31:0] obs_d1, obs_d2;

  function automatic void fwd_model(input logic [4:0] sel, output bit hit, output logic [31:0] d);
    hit = 1'b0;
    d   = 32'd0;
    if (sel != 5'd0) begin
      if (m_wen && m_sel == sel) begin hit = 1'b1; d = m_data; end
      foreach (mq[i]) if (mq[i].rd == sel) begin hit = 1'b1; d = mq[i].data; end
    end
  endfunction

  // One clock: drive at negedge, sample pre-edge outputs, advance model, return at next negedge.
  task automatic cycle(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                       input bit bv, input logic [4:0] brd, input logic [31:0] bd,
                       input logic [4:0] s1, input logic [4:0] s2);
    int fr;
    a_valid = av; a_rd = ard; a_data = ad;
    b_valid = bv; b_rd = brd; b_data = bd;
    fwd_sel1 = s1; fwd_sel2 = s2;
    fr = 4 - mq.size();
    exp_ar = (fr >= 1);
    exp_br = (fr >= 2) || (fr >= 1 && !av);
    fwd_model(s1, exp_h1, exp_d1);
    fwd_model(s2, exp_h2, exp_d2);
    #1;
    obs_ar = a_ready; obs_br = b_ready;
    obs_h1 = fwd_hit1; obs_d1 = fwd_data1;
    obs_h2 = fwd_hit2; obs_d2 = fwd_data2;
    @(posedge clock);
    if (mq.size() > 0) begin
      m_wen = 1'b1; m_sel = mq[0].rd; m_data = mq[0].data;
      mq.delete(0);
    end else begin
      m_wen = 1'b0;
    end
    if (av && exp_ar && ard != 5'd0) mq.push_back('{ard, ad});
    if (bv && exp_br && brd != 5'd0) mq.push_back('{brd, bd});
    @(negedge clock);
  endtask

  task automatic idle(input logic [4:0] s1, input logic [4:0] s2);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, s1, s2);
  endtask

  task automatic do_reset();
    reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    #1;
    obs_ar = a_ready; obs_br = b_ready;
    @(posedge clock);
    mq.delete(); m_wen = 1'b0; m_sel = 5'd0; m_data = 32'd0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (obs_ar !== 1'b0 || obs_br !== 1'b0) begin failures++; $display("FAIL reset_ready got a=%b b=%b exp 0 0", obs_ar, obs_br); end
    checks++; if (rf_wEn !== 1'b0) begin failures++; $display("FAIL reset_wen got=%b exp=0", rf_wEn); end
    checks++; if (rf_write_sel !== 5'd0 || rf_write_data !== 32'd0) begin failures++; $display("FAIL reset_port got sel=%0d data=%h exp 0 0", rf_write_sel, rf_write_data); end
    checks++; if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL reset_occ got count=%0d empty=%b full=%b exp 0 1 0", count, empty, full); end
  endtask

  task automatic test_a_only();
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    checks++; if (obs_ar !== 1'b1 || count !== 3'd1 || rf_wEn !== 1'b0) begin failures++; $display("FAIL aonly_accept got ready=%b count=%0d wen=%b exp 1 1 0", obs_ar, count, rf_wEn); end
    idle(5'd0, 5'd0);
    checks++; if (rf_wEn !== 1'b1 || rf_write_sel !== 5'd5 || rf_write_data !== 32'hDEADBEEF) begin failures++; $display("FAIL aonly_write got wen=%b sel=%0d data=%h exp 1 5 deadbeef", rf_wEn, rf_write_sel, rf_write_data); end
    idle(5'd0, 5'd0);
    checks++; if (rf_wEn !== 1'b0 || empty !== 1'b1 || rf_write_sel !== 5'd5) begin failures++; $display("FAIL aonly_after got wen=%b empty=%b sel=%0d exp 0 1 5", rf_wEn, empty, rf_write_sel); end
  endtask

  task automatic test_both_same_rd();
    cycle(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 5'd3, 5'd0);
    checks++; if (obs_ar !== 1'b1 || obs_br !== 1'b1 || count !== 3'd2) begin failures++; $display("FAIL both_accept got a=%b b=%b count=%0d exp 1 1 2", obs_ar, obs_br, count); end
    idle(5'd3, 5'd0);
    checks++; if (obs_h1 !== 1'b1 || obs_d1 !== 32'h22) begin failures++; $display("FAIL both_fwd_q2 got hit=%b data=%h exp 1 22", obs_h1, obs_d1); end
    checks++; if (rf_wEn !== 1'b1 || rf_write_data !== 32'h11) begin failures++; $display("FAIL both_first got wen=%b data=%h exp 1 11", rf_wEn, rf_write_data); end
    idle(5'd3, 5'd0);
    checks++; if (obs_h1 !== 1'b1 || obs_d1 !== 32'h22) begin failures++; $display("FAIL both_fwd_q1 got hit=%b data=%h exp 1 22", obs_h1, obs_d1); end
    checks++; if (rf_wEn !== 1'b1 || rf_write_data !== 32'h22) begin failures++; $display("FAIL both_second got wen=%b data=%h exp 1 22", rf_wEn, rf_write_data); end
    idle(5'd3, 5'd0);
    checks++; if (obs_h1 !== 1'b1 || obs_d1 !== 32'h22) begin failures++; $display("FAIL both_fwd_out got hit=%b data=%h exp 1 22", obs_h1, obs_d1); end
  endtask

  task automatic test_fill();
    cycle(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB2, 5'd0, 5'd0);
    cycle(1'b1, 5'd3, 32'hA3, 1'b1, 5'd4, 32'hB4, 5'd0, 5'd0);
    checks++; if (obs_ar !== 1'b1 || obs_br !== 1'b1 || count !== 3'd3) begin failures++; $display("FAIL fill_free2 got a=%b b=%b count=%0d exp 1 1 3", obs_ar, obs_br, count); end
    cycle(1'b1, 5'd5, 32'hA5, 1'b1, 5'd6, 32'hB6, 5'd0, 5'd0);
    checks++; if (obs_ar !== 1'b1 || obs_br !== 1'b0) begin failures++; $display("FAIL fill_last_slot got a=%b b=%b exp 1 0", obs_ar, obs_br); end
    checks++; if (count !== 3'd3 || full !== 1'b0) begin failures++; $display("FAIL fill_count got count=%0d full=%b exp 3 0", count, full); end
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hB7, 5'd0, 5'd0);
    checks++; if (obs_br !== 1'b1) begin failures++; $display("FAIL fill_b_alone got b=%b exp 1", obs_br); end
    for (int i = 0; i < 4; i++) idle(5'd0, 5'd0);
    checks++; if (empty !== 1'b1 || rf_wEn !== 1'b0) begin failures++; $display("FAIL fill_drain got empty=%b wen=%b exp 1 0", empty, rf_wEn); end
  endtask

  task automatic test_zero_reg();
    cycle(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    checks++; if (obs_ar !== 1'b1 || count !== 3'd0) begin failures++; $display("FAIL zero_accept got ready=%b count=%0d exp 1 0", obs_ar, count); end
    checks++; if (obs_h1 !== 1'b0 || obs_d1 !== 32'd0) begin failures++; $display("FAIL zero_fwd got hit=%b data=%h exp 0 0", obs_h1, obs_d1); end
    idle(5'd0, 5'd0);
    checks++; if (rf_wEn !== 1'b0) begin failures++; $display("FAIL zero_nowrite got wen=%b exp 0", rf_wEn); end
  endtask

  task automatic test_wrap();
    logic [4:0]  got_rd[$];
    logic [31:0] got_d[$];
    logic [31:0] exp_d[$];
    logic [31:0] d;
    for (int i = 1; i <= 12; i++) begin
      if (i <= 10) begin
        d = $urandom;
        exp_d.push_back(d);
        cycle(1'b1, 5'(i), d, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      end else begin
        idle(5'd0, 5'd0);
      end
      if (rf_wEn === 1'b1) begin got_rd.push_back(rf_write_sel); got_d.push_back(rf_write_data); end
    end
    checks++; if (got_rd.size() != 10) begin failures++; $display("FAIL wrap_count got=%0d exp=10", got_rd.size()); end
    for (int i = 0; i < 10 && i < got_rd.size(); i++) begin
      checks++;
      if (got_rd[i] !== 5'(i + 1) || got_d[i] !== exp_d[i]) begin
        failures++; $display("FAIL wrap_order idx=%0d got rd=%0d data=%h exp rd=%0d data=%h", i, got_rd[i], got_d[i], i + 1, exp_d[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    cycle(1'b1, 5'd7, 32'h70, 1'b1, 5'd8, 32'h80, 5'd0, 5'd0);
    cycle(1'b1, 5'd9, 32'h90, 1'b1, 5'd10, 32'hA0, 5'd0, 5'd0);
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL midrst_pre got count=%0d exp 3", count); end
    do_reset();
    checks++; if (count !== 3'd0 || rf_wEn !== 1'b0) begin failures++; $display("FAIL midrst_clear got count=%0d wen=%b exp 0 0", count, rf_wEn); end
    idle(5'd9, 5'd10);
    checks++; if (obs_h1 !== 1'b0 || obs_h2 !== 1'b0) begin failures++; $display("FAIL midrst_fwd got h1=%b h2=%b exp 0 0", obs_h1, obs_h2); end
    checks++; if (rf_wEn !== 1'b0) begin failures++; $display("FAIL midrst_stale got wen=%b exp 0", rf_wEn); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 63) == 0) do_reset();
      cycle($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      checks++; if (obs_ar !== exp_ar || obs_br !== exp_br) begin failures++; $display("FAIL rnd_ready n=%0d got a=%b b=%b exp %b %b", n, obs_ar, obs_br, exp_ar, exp_br); end
      checks++; if (obs_h1 !== exp_h1 || obs_d1 !== exp_d1) begin failures++; $display("FAIL rnd_fwd1 n=%0d got %b %h exp %b %h", n, obs_h1, obs_d1, exp_h1, exp_d1); end
      checks++; if (obs_h2 !== exp_h2 || obs_d2 !== exp_d2) begin failures++; $display("FAIL rnd_fwd2 n=%0d got %b %h exp %b %h", n, obs_h2, obs_d2, exp_h2, exp_d2); end
      checks++; if (rf_wEn !== m_wen || rf_write_sel !== m_sel || rf_write_data !== m_data) begin failures++; $display("FAIL rnd_port n=%0d got %b %0d %h exp %b %0d %h", n, rf_wEn, rf_write_sel, rf_write_data, m_wen, m_sel, m_data); end
      checks++; if (count !== 3'(mq.size()) || full !== (mq.size() == 4) || empty !== (mq.size() == 0)) begin failures++; $display("FAIL rnd_occ n=%0d got count=%0d full=%b empty=%b exp count=%0d", n, count, full, empty, mq.size()); end
    end
  endtask

  initial begin
    reset = 1'b1;
    a_valid = 1'b0; a_rd = 5'd0; a_data = 32'd0;
    b_valid = 1'b0; b_rd = 5'd0; b_data = 32'd0;
    fwd_sel1 = 5'd0; fwd_sel2 = 5'd0;
    test_reset();
    test_a_only();
    test_both_same_rd();
    test_fill();
    test_zero_reg();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
